vga_timing_gen: RTL

Free-running VGA raster timing generator. It sits directly upstream of the pattern/bitmap renderer in the top-level wrapper and supplies the renderer's pixel coordinates, sync pulses, active-video flag and per-frame/per-line strobes. All outputs are registered and mutually aligned, so every output in a given cycle describes the same pixel. Default timing is 640x480 @ 60 Hz with a 25.175 MHz pixel clock.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, syncs, active-video flag and strobes.
// All outputs are registered from the same edge; ce=0 freezes the raster and zeroes the strobes.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_BOTTOM);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_timing_gen: raster totals exceed 10-bit counters");
    end

    logic [9:0]  hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        disp_q, disp_d;
    logic        line_q, line_d;
    logic        frame_q, frame_d;
    logic        vblank_q, vblank_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic        h_wrap;
    logic [9:0]  h_nxt;
    logic [9:0]  v_nxt;

    always_comb begin
        h_wrap = (hpos_q == H_MAX);
        h_nxt  = h_wrap ? 10'd0 : hpos_q + 10'd1;
        v_nxt  = vpos_q;
        if (h_wrap) begin
            v_nxt = (vpos_q == V_MAX) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Decode is done on the next counter values so every registered output describes the same pixel.
    always_comb begin
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        disp_d   = disp_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        vblank_d = 1'b0;
        fcnt_d   = fcnt_q;
        if (ce) begin
            hpos_d   = h_nxt;
            vpos_d   = v_nxt;
            hsync_d  = (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
            disp_d   = (h_nxt < H_VIS) && (v_nxt < V_VIS);
            line_d   = (h_nxt == 10'd0);
            frame_d  = (h_nxt == 10'd0) && (v_nxt == 10'd0);
            vblank_d = (h_nxt == 10'd0) && (v_nxt == V_VIS);
            if (frame_d) begin
                fcnt_d = fcnt_q + 16'd1;
            end
        end
    end

    // Reset parks the raster on the last pixel so the first advance lands on (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q   <= H_MAX;
            vpos_q   <= V_MAX;
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            disp_q   <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;
            fcnt_q   <= 16'd0;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            disp_q   <= disp_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            vblank_q <= vblank_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign display_on   = disp_q;
    assign line_start   = line_q;
    assign frame_start  = frame_q;
    assign vblank_start = vblank_q;
    assign frame_count  = fcnt_q;

endmodule
